// File: rtl/vu_frame_parser.sv
// VU meter frame parser: pulls 4-byte frames (sync, left, right, checksum)
// out of a UART byte stream. It publishes the left/right levels only when the
// checksum matches, and drops partial frames that stall for too long.
module vu_frame_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 48000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_dv,
  output logic [7:0] o_level_l,
  output logic [7:0] o_level_r,
  output logic       o_update,
  output logic       o_err
);

  // One extra bit so the counter cannot wrap before it reaches the terminal count.
  localparam int                CNT_W    = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    GET_L     = 2'd1,
    GET_R     = 2'd2,
    GET_CHK   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             dv_q;
  logic             strobe;
  logic             timeout_hit;
  logic [CNT_W-1:0] timeout_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       l_tmp;
  logic [7:0]       l_tmp_nxt;
  logic [7:0]       r_tmp;
  logic [7:0]       r_tmp_nxt;
  logic [7:0]       level_l_nxt;
  logic [7:0]       level_r_nxt;
  logic             update_nxt;
  logic             err_nxt;

  // The receiver's valid line idles high, so a new byte is its rising edge.
  assign strobe = i_dv & ~dv_q;

  // Next-state, temporaries, idle timeout and output pulses for the parser.
  always_comb begin
    state_nxt   = state;
    l_tmp_nxt   = l_tmp;
    r_tmp_nxt   = r_tmp;
    level_l_nxt = o_level_l;
    level_r_nxt = o_level_r;
    update_nxt  = 1'b0;
    err_nxt     = 1'b0;
    cnt_nxt     = timeout_cnt + CNT_ONE;
    timeout_hit = 1'b0;

    if (state == WAIT_SYNC || strobe) begin
      cnt_nxt = '0;
    end

    // A byte arriving in the last allowed cycle still counts as on time.
    if (state != WAIT_SYNC && !strobe && timeout_cnt == CNT_LAST) begin
      timeout_hit = 1'b1;
      err_nxt     = 1'b1;
      cnt_nxt     = '0;
      state_nxt   = WAIT_SYNC;
    end else if (strobe) begin
      case (state)
        WAIT_SYNC: begin
          if (i_data == SYNC_BYTE) begin
            state_nxt = GET_L;
          end
        end
        GET_L: begin
          l_tmp_nxt = i_data;
          state_nxt = GET_R;
        end
        GET_R: begin
          r_tmp_nxt = i_data;
          state_nxt = GET_CHK;
        end
        GET_CHK: begin
          if (i_data == (l_tmp ^ r_tmp)) begin
            level_l_nxt = l_tmp;
            level_r_nxt = r_tmp;
            update_nxt  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
          state_nxt = WAIT_SYNC;
        end
        default: begin
          state_nxt = WAIT_SYNC;
        end
      endcase
    end
  end

  // Register everything; dv_q comes out of reset high so an idle-high line gives no strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= WAIT_SYNC;
      dv_q        <= 1'b1;
      timeout_cnt <= '0;
      l_tmp       <= 8'h00;
      r_tmp       <= 8'h00;
      o_level_l   <= 8'h00;
      o_level_r   <= 8'h00;
      o_update    <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      dv_q        <= i_dv;
      timeout_cnt <= cnt_nxt;
      l_tmp       <= l_tmp_nxt;
      r_tmp       <= r_tmp_nxt;
      o_level_l   <= level_l_nxt;
      o_level_r   <= level_r_nxt;
      o_update    <= update_nxt;
      o_err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_vu_frame_parser.sv
// Directed bench for vu_frame_parser. Instance A uses the default 48000-clock
// timeout. Instance B uses a short timeout so the byte-versus-timeout race can
// be hit exactly.
module tb_vu_frame_parser;

  localparam int TA = 48000;
  localparam int TB = 8;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] data_a;
  logic       dv_a;
  logic [7:0] data_b;
  logic       dv_b;
  logic [7:0] lvl_l_a;
  logic [7:0] lvl_r_a;
  logic       upd_a;
  logic       err_a;
  logic [7:0] lvl_l_b;
  logic [7:0] lvl_r_b;
  logic       upd_b;
  logic       err_b;

  int checks;
  int failures;
  int upd_cnt_a;
  int err_cnt_a;
  int both_cnt_a;
  int upd_cnt_b;
  int err_cnt_b;
  int both_cnt_b;

  vu_frame_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TA)) dut_a (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_data    (data_a),
    .i_dv      (dv_a),
    .o_level_l (lvl_l_a),
    .o_level_r (lvl_r_a),
    .o_update  (upd_a),
    .o_err     (err_a)
  );

  vu_frame_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TB)) dut_b (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_data    (data_b),
    .i_dv      (dv_b),
    .o_level_l (lvl_l_b),
    .o_level_r (lvl_r_b),
    .o_update  (upd_b),
    .o_err     (err_b)
  );

  // 48 MHz-ish free-running clock.
  initial begin
    i_clk = 1'b0;
    forever #10 i_clk = ~i_clk;
  end

  // Count every cycle each pulse is high, plus any cycle where both are high.
  always @(posedge i_clk) begin
    #1;
    if (upd_a) upd_cnt_a++;
    if (err_a) err_cnt_a++;
    if (upd_a && err_a) both_cnt_a++;
    if (upd_b) upd_cnt_b++;
    if (err_b) err_cnt_b++;
    if (upd_b && err_b) both_cnt_b++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Send one byte as a low pulse on the valid line; returns on the negedge after the strobe edge.
  task automatic applyStimulus(input int sel, input logic [7:0] b);
    @(negedge i_clk);
    if (sel == 0) begin dv_a = 1'b0; data_a = b; end
    else          begin dv_b = 1'b0; data_b = b; end
    repeat (2) @(negedge i_clk);
    if (sel == 0) dv_a = 1'b1;
    else          dv_b = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic pulseReset(input int cycles);
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (cycles) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    upd_cnt_a = 0; err_cnt_a = 0; both_cnt_a = 0;
    upd_cnt_b = 0; err_cnt_b = 0; both_cnt_b = 0;
    i_rst = 1'b1;
    dv_a = 1'b1; data_a = 8'hA5;
    dv_b = 1'b1; data_b = 8'hA5;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("reset_level_l", lvl_l_a, 8'h00);
    checkOutput("reset_level_r", lvl_r_a, 8'h00);
    checkOutput("reset_update", upd_a, 1'b0);
    checkOutput("reset_err", err_a, 1'b0);

    // Valid line high with a sync byte on the data lines through reset release: no phantom strobe.
    repeat (4) @(negedge i_clk);
    applyStimulus(0, 8'h40); applyStimulus(0, 8'hC0); applyStimulus(0, 8'h80);
    checkOutput("no_strobe_after_reset_upd", upd_cnt_a, 0);
    checkOutput("no_strobe_after_reset_lvl", lvl_l_a, 8'h00);

    // A good frame.
    applyStimulus(0, 8'hA5); applyStimulus(0, 8'h40); applyStimulus(0, 8'hC0);
    applyStimulus(0, 8'h80);
    checkOutput("good_update_pulse", upd_a, 1'b1);
    checkOutput("good_level_l", lvl_l_a, 8'h40);
    checkOutput("good_level_r", lvl_r_a, 8'hC0);
    @(negedge i_clk);
    checkOutput("good_update_drop", upd_a, 1'b0);
    checkOutput("good_update_count", upd_cnt_a, 1);

    // A bad checksum.
    applyStimulus(0, 8'hA5); applyStimulus(0, 8'h12); applyStimulus(0, 8'h34);
    applyStimulus(0, 8'h00);
    checkOutput("badchk_err_pulse", err_a, 1'b1);
    @(negedge i_clk);
    checkOutput("badchk_err_drop", err_a, 1'b0);
    checkOutput("badchk_err_count", err_cnt_a, 1);
    checkOutput("badchk_update_count", upd_cnt_a, 1);
    checkOutput("badchk_level_l", lvl_l_a, 8'h40);
    checkOutput("badchk_level_r", lvl_r_a, 8'hC0);

    // Leading junk bytes ignored silently.
    applyStimulus(0, 8'h00); applyStimulus(0, 8'hFF); applyStimulus(0, 8'hA5);
    applyStimulus(0, 8'h01); applyStimulus(0, 8'h02); applyStimulus(0, 8'h03);
    checkOutput("junk_level_l", lvl_l_a, 8'h01);
    checkOutput("junk_level_r", lvl_r_a, 8'h02);
    checkOutput("junk_update_count", upd_cnt_a, 2);
    checkOutput("junk_err_count", err_cnt_a, 1);

    // Valid line held high for 100 cycles after a byte gives only one strobe.
    applyStimulus(0, 8'hA5);
    repeat (100) @(negedge i_clk);
    applyStimulus(0, 8'h11); applyStimulus(0, 8'h22); applyStimulus(0, 8'h33);
    checkOutput("hold_level_l", lvl_l_a, 8'h11);
    checkOutput("hold_level_r", lvl_r_a, 8'h22);
    checkOutput("hold_update_count", upd_cnt_a, 3);

    // A sync byte in the L position is data, not a resync.
    applyStimulus(0, 8'hA5); applyStimulus(0, 8'hA5); applyStimulus(0, 8'h0F);
    applyStimulus(0, 8'hAA);
    checkOutput("sync_as_data_l", lvl_l_a, 8'hA5);
    checkOutput("sync_as_data_r", lvl_r_a, 8'h0F);
    checkOutput("sync_as_data_count", upd_cnt_a, 4);

    // Reset mid-frame discards the partial frame quietly.
    applyStimulus(0, 8'hA5); applyStimulus(0, 8'h20);
    pulseReset(1);
    @(negedge i_clk);
    checkOutput("midreset_err_count", err_cnt_a, 1);
    checkOutput("midreset_level_l", lvl_l_a, 8'h00);
    applyStimulus(0, 8'h20); applyStimulus(0, 8'h30); applyStimulus(0, 8'h10);
    checkOutput("midreset_tail_ignored", upd_cnt_a, 4);
    applyStimulus(0, 8'hA5); applyStimulus(0, 8'h20); applyStimulus(0, 8'h30);
    applyStimulus(0, 8'h10);
    checkOutput("midreset_level_l2", lvl_l_a, 8'h20);
    checkOutput("midreset_level_r2", lvl_r_a, 8'h30);
    checkOutput("midreset_update_count", upd_cnt_a, 5);

    // Idle timeout at the full 48000-clock setting, then recovery.
    applyStimulus(0, 8'hA5); applyStimulus(0, 8'h10);
    repeat (TA - 1) @(negedge i_clk);
    checkOutput("timeout_not_early", err_a, 1'b0);
    @(negedge i_clk);
    checkOutput("timeout_err_pulse", err_a, 1'b1);
    @(negedge i_clk);
    checkOutput("timeout_err_count", err_cnt_a, 2);
    checkOutput("timeout_level_kept", lvl_l_a, 8'h20);
    applyStimulus(0, 8'hA5); applyStimulus(0, 8'h05); applyStimulus(0, 8'h06);
    applyStimulus(0, 8'h03);
    checkOutput("after_timeout_l", lvl_l_a, 8'h05);
    checkOutput("after_timeout_r", lvl_r_a, 8'h06);
    checkOutput("after_timeout_update_count", upd_cnt_a, 6);

    // Short-timeout instance: exact timeout boundary.
    applyStimulus(1, 8'hA5);
    repeat (TB - 1) @(negedge i_clk);
    checkOutput("b_timeout_not_early", err_b, 1'b0);
    @(negedge i_clk);
    checkOutput("b_timeout_err_pulse", err_b, 1'b1);
    @(negedge i_clk);
    checkOutput("b_timeout_err_count", err_cnt_b, 1);

    // Byte strobe landing in the timeout cycle wins over the timeout.
    applyStimulus(1, 8'hA5);
    repeat (TB - 3) @(negedge i_clk);
    dv_b = 1'b0; data_b = 8'h05;
    repeat (2) @(negedge i_clk);
    dv_b = 1'b1;
    @(negedge i_clk);
    checkOutput("b_race_no_err", err_b, 1'b0);
    applyStimulus(1, 8'h06); applyStimulus(1, 8'h03);
    checkOutput("b_race_level_l", lvl_l_b, 8'h05);
    checkOutput("b_race_level_r", lvl_r_b, 8'h06);
    checkOutput("b_race_update_count", upd_cnt_b, 1);
    checkOutput("b_race_err_count", err_cnt_b, 1);

    repeat (2) @(negedge i_clk);
    checkOutput("a_never_both", both_cnt_a, 0);
    checkOutput("b_never_both", both_cnt_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
